// File: rtl/audio_rec_play.sv
// -----------------------------------------------------------------------------
// audio_rec_play
//
// Record/playback buffer for the WM8978 codec data path.
//
// Recording: every rx_done strobe in REC stores the 32-bit stereo word on
// adc_data into an inferred simple dual-port RAM. Recording stops when the
// RAM is full or on a stop pulse.
//
// Playback: the recorded words are replayed on dac_data one word per tx_done
// strobe. The read address is registered and dac_data acts as the RAM output
// register, so a new word appears two cycles after its tx_done strobe.
//
// The whole block runs on the codec bit clock, so the rx_done and tx_done
// strobes are already synchronous to clk.
//
// Optional build macro:
//   AUDIO_MONITOR_EN - when defined, dac_data follows adc_data on every rx_done
//                      while in IDLE or REC, for live monitoring. When
//                      undefined, dac_data is 0 in IDLE and REC.
// -----------------------------------------------------------------------------
module audio_rec_play #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rec_start,
  input  logic          play_start,
  input  logic          stop,
  input  logic          rx_done,
  input  logic [DW-1:0] adc_data,
  input  logic          tx_done,
  output logic [DW-1:0] dac_data,
  output logic          recording,
  output logic          playing,
  output logic          full,
  output logic [AW:0]   rec_len
);

  // Word count of a completely filled RAM (2^AW).
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PEND = 2'd2,
    ST_PLAY = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW:0]   rd_addr_q, rd_addr_d;
  logic [AW:0]   rec_len_q, rec_len_d;
  logic          full_q, full_d;
  logic [DW-1:0] dac_data_q, dac_data_d;
  logic          recording_q, playing_q;
  logic          ld_q, ld_d;
  logic          wr_en;
  logic [DW-1:0] ram_rd;
  logic [AW:0]   rd_next;

  logic [DW-1:0] mem_q [2**AW];

  assign ram_rd  = mem_q[rd_addr_q[AW-1:0]];
  assign rd_next = rd_addr_q + 1'b1;

  // Next-state, address, length and output-word decode.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    rec_len_d  = rec_len_q;
    full_d     = full_q;
    dac_data_d = dac_data_q;
    ld_d       = 1'b0;
    wr_en      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // stop outranks the start commands, even though it does nothing here.
        if (!stop) begin
          if (rec_start) begin
            state_d   = ST_REC;
            wr_addr_d = '0;
            rec_len_d = '0;
            full_d    = 1'b0;
          end else if (play_start && (rec_len_q != '0)) begin
            state_d   = ST_PEND;
            rd_addr_d = '0;
          end
        end
`ifdef AUDIO_MONITOR_EN
        if (rx_done) dac_data_d = adc_data;
`endif
      end

      ST_REC: begin
        // A word strobed together with stop is still stored.
        if (rx_done) begin
          wr_en     = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          rec_len_d = rec_len_q + 1'b1;
          if (rec_len_q + 1'b1 == DEPTH) begin
            full_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        if (stop) state_d = ST_IDLE;
`ifdef AUDIO_MONITOR_EN
        if (rx_done) dac_data_d = adc_data;
`endif
      end

      ST_PEND: begin
        // rd_addr_q is 0 here, so the RAM presents word 0.
        if (stop) begin
          state_d    = ST_IDLE;
          dac_data_d = '0;
        end else begin
          state_d    = ST_PLAY;
          dac_data_d = ram_rd;
        end
      end

      ST_PLAY: begin
        // One cycle after a tx_done the advanced address is on the RAM.
        if (ld_q) dac_data_d = ram_rd;
        if (stop) begin
          state_d    = ST_IDLE;
          dac_data_d = '0;
        end else if (tx_done) begin
          rd_addr_d = rd_next;
          if (rd_next == rec_len_q) begin
            state_d    = ST_IDLE;
            dac_data_d = '0;
          end else begin
            ld_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      rec_len_q   <= '0;
      full_q      <= 1'b0;
      dac_data_q  <= '0;
      recording_q <= 1'b0;
      playing_q   <= 1'b0;
      ld_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      rec_len_q   <= rec_len_d;
      full_q      <= full_d;
      dac_data_q  <= dac_data_d;
      recording_q <= (state_d == ST_REC);
      playing_q   <= (state_d == ST_PLAY);
      ld_q        <= ld_d;
    end
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset so it maps onto block RAM. Its contents are
    // only ever read below rec_len, which is reset.
    if (wr_en) mem_q[wr_addr_q] <= adc_data;
  end

  assign dac_data  = dac_data_q;
  assign recording = recording_q;
  assign playing   = playing_q;
  assign full      = full_q;
  assign rec_len   = rec_len_q;

endmodule

// File: tb/tb_audio_rec_play.sv
// -----------------------------------------------------------------------------
// tb_audio_rec_play
//
// Cycle-level bench for audio_rec_play, built with AW = 3 (8-word RAM).
//
// Each table row holds the inputs applied for one clock cycle and the outputs
// expected after that cycle's rising edge. Inputs are driven on the falling
// edge and the expectation is queued at the same time. The queued value is
// popped and compared on the next falling edge. A few hand-written sequences
// cover asynchronous reset.
// -----------------------------------------------------------------------------
module tb_audio_rec_play;

  localparam int DW = 32;
  localparam int AW = 3;

  typedef struct packed {
    logic          rec_start;
    logic          play_start;
    logic          stop;
    logic          rx_done;
    logic [DW-1:0] adc;
    logic          tx_done;
  } in_t;

  typedef struct packed {
    logic [DW-1:0] dac;
    logic          rec;
    logic          play;
    logic          full;
    logic [AW:0]   len;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rec_start = 1'b0;
  logic          play_start = 1'b0;
  logic          stop = 1'b0;
  logic          rx_done = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          tx_done = 1'b0;
  logic [DW-1:0] dac_data;
  logic          recording;
  logic          playing;
  logic          full;
  logic [AW:0]   rec_len;

  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs[$];
  out_t exp_q[$];

  audio_rec_play #(.DW(DW), .AW(AW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rec_start  (rec_start),
    .play_start (play_start),
    .stop       (stop),
    .rx_done    (rx_done),
    .adc_data   (adc_data),
    .tx_done    (tx_done),
    .dac_data   (dac_data),
    .recording  (recording),
    .playing    (playing),
    .full       (full),
    .rec_len    (rec_len)
  );

  always #5 clk = ~clk;

  function automatic out_t cur_out();
    out_t o;
    o.dac  = dac_data;
    o.rec  = recording;
    o.play = playing;
    o.full = full;
    o.len  = rec_len;
    return o;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got dac=%h rec=%b play=%b full=%b len=%0d, expected dac=%h rec=%b play=%b full=%b len=%0d",
               name, act.dac, act.rec, act.play, act.full, act.len,
               exp.dac, exp.rec, exp.play, exp.full, exp.len);
    end
  endtask

  // Row builder: command bits, rx/tx strobes and the expected outputs.
  task automatic add(input logic rs, input logic ps, input logic sp,
                     input logic rx, input logic [DW-1:0] adc, input logic tx,
                     input logic [DW-1:0] dac, input logic rec, input logic play,
                     input logic fl, input int len);
    vec_t v;
    v.i = '{rec_start: rs, play_start: ps, stop: sp, rx_done: rx, adc: adc, tx_done: tx};
    v.o = '{dac: dac, rec: rec, play: play, full: fl, len: (AW+1)'(len)};
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t i);
    rec_start  = i.rec_start;
    play_start = i.play_start;
    stop       = i.stop;
    rx_done    = i.rx_done;
    adc_data   = i.adc;
    tx_done    = i.tx_done;
  endtask

  logic [DW-1:0] w8 [8];
  logic [DW-1:0] w2 [2];

  initial begin
    for (int k = 0; k < 8; k++) w8[k] = 32'hC0DE_0000 + DW'(k * 32'h0001_0011);
    w2[0] = 32'h5A5A_0001;
    w2[1] = 32'hA5A5_0002;

    // rx_done strobes in IDLE are ignored.
    for (int k = 0; k < 5; k++) add(0,0,0, 1,32'h1234_5678, 0,  '0,0,0,0,0);
    // play_start with an empty RAM is ignored, also one cycle later.
    add(0,1,0, 0,'0,0,  '0,0,0,0,0);
    add(0,0,0, 0,'0,0,  '0,0,0,0,0);
    add(0,0,0, 0,'0,0,  '0,0,0,0,0);
    // rec_start and play_start together: recording wins.
    add(1,1,0, 0,'0,0,  '0,1,0,0,0);
    add(0,0,0, 1,32'h0001_0001,0,  '0,1,0,0,1);
    add(0,0,0, 1,32'h0002_0002,0,  '0,1,0,0,2);
    add(0,0,0, 0,'0,0,             '0,1,0,0,2);
    add(0,0,0, 1,32'h0003_0003,0,  '0,1,0,0,3);
    add(0,0,0, 1,32'h0004_0004,0,  '0,1,0,0,4);
    add(0,0,1, 0,'0,0,             '0,0,0,0,4);
    // tx_done outside PLAY is ignored.
    add(0,0,0, 0,'0,1,             '0,0,0,0,4);
    // Play back: PEND, then word 0, then each word two cycles after tx_done.
    add(0,1,0, 0,'0,0,  '0,0,0,0,4);
    add(0,0,0, 0,'0,0,  32'h0001_0001,0,1,0,4);
    add(0,0,0, 0,'0,1,  32'h0001_0001,0,1,0,4);
    add(0,0,0, 0,'0,0,  32'h0002_0002,0,1,0,4);
    add(0,0,0, 0,'0,1,  32'h0002_0002,0,1,0,4);
    add(0,0,0, 0,'0,0,  32'h0003_0003,0,1,0,4);
    add(0,0,0, 0,'0,1,  32'h0003_0003,0,1,0,4);
    add(0,0,0, 0,'0,0,  32'h0004_0004,0,1,0,4);
    add(0,0,0, 0,'0,0,  32'h0004_0004,0,1,0,4);
    // The last tx_done drops playing and clears dac_data after one cycle.
    add(0,0,0, 0,'0,1,  '0,0,0,0,4);
    add(0,0,0, 0,'0,0,  '0,0,0,0,4);
    // A second playback repeats from word 0; stop aborts it.
    add(0,1,0, 0,'0,0,  '0,0,0,0,4);
    add(0,0,0, 0,'0,0,  32'h0001_0001,0,1,0,4);
    add(0,0,1, 0,'0,1,  '0,0,0,0,4);
    add(0,0,0, 0,'0,0,  '0,0,0,0,4);
    // Fill the RAM: 10 strobes, full and IDLE after the 8th.
    add(1,0,0, 0,'0,0,  '0,1,0,0,0);
    for (int k = 0; k < 10; k++)
      add(0,0,0, 1,(k < 8) ? w8[k] : 32'hDEAD_0000 + DW'(k), 0,
          '0, (k < 7), 0, (k >= 7), (k < 8) ? k + 1 : 8);
    // Replay all 8 words; the 9th and 10th were not written.
    add(0,1,0, 0,'0,0,  '0,0,0,1,8);
    add(0,0,0, 0,'0,0,  w8[0],0,1,1,8);
    for (int k = 1; k < 8; k++) begin
      add(0,0,0, 0,'0,1,  w8[k-1],0,1,1,8);
      add(0,0,0, 0,'0,0,  w8[k],0,1,1,8);
    end
    add(0,0,0, 0,'0,1,  '0,0,0,1,8);
    // A new recording clears full; stop together with rx_done keeps the word.
    add(1,0,0, 0,'0,0,      '0,1,0,0,0);
    add(0,0,0, 1,w2[0],0,   '0,1,0,0,1);
    add(0,0,1, 1,w2[1],0,   '0,0,0,0,2);
    add(0,0,0, 1,32'hFFFF_FFFF,0, '0,0,0,0,2);
    add(0,1,0, 0,'0,0,  '0,0,0,0,2);
    add(0,0,0, 0,'0,0,  w2[0],0,1,0,2);
    add(0,0,0, 0,'0,1,  w2[0],0,1,0,2);
    add(0,0,0, 0,'0,0,  w2[1],0,1,0,2);
    add(0,0,0, 0,'0,1,  '0,0,0,0,2);
    // Re-enter PLAY for the asynchronous reset sequence below.
    add(0,1,0, 0,'0,0,  '0,0,0,0,2);
    add(0,0,0, 0,'0,0,  w2[0],0,1,0,2);

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_state", cur_out(), '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_release", cur_out(), '0);

    // Table-driven run with scoreboard.
    foreach (vecs[k]) begin
      @(negedge clk);
      if (exp_q.size() != 0) check($sformatf("vec[%0d]", k - 1), cur_out(), exp_q.pop_front());
      drive(vecs[k].i);
      exp_q.push_back(vecs[k].o);
    end
    @(negedge clk);
    check($sformatf("vec[%0d]", vecs.size() - 1), cur_out(), exp_q.pop_front());
    drive('0);

    // Reset mid-PLAY clears every output without waiting for a clock edge.
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid_play", cur_out(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", cur_out(), '0);

    // The recording length was lost, so play_start is now ignored.
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    @(negedge clk);
    check("play_ignored_after_reset", cur_out(), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/audio_rec_play.md
# audio_rec_play

Record/playback buffer that sits between the WM8978 codec control block's receive and send paths. It captures the 32-bit stereo words delivered on each `rx_done` into on-chip RAM, then replays them word-by-word on `tx_done` through `dac_data`. It runs in the codec bit-clock domain, so the receive and send strobes are synchronous to its clock and need no synchronizers.

## Interface
Parameters:
- `DW`, 32, sample word width (left in [31:16], right in [15:0]).
- `AW`, 10, RAM address width; depth = 2^AW words.

Ports:
- `clk`  in  1  clock, driven by the codec bit clock (aud_bclk).
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rec_start`  in  1  single-cycle pulse: begin recording.
- `play_start`  in  1  single-cycle pulse: begin playback.
- `stop`  in  1  single-cycle pulse: abort recording or playback.
- `rx_done`  in  1  one-cycle strobe: `adc_data` holds a new valid word.
- `adc_data`  in  DW  captured word.
- `tx_done`  in  1  one-cycle strobe: the current `dac_data` word has been sent.
- `dac_data`  out  DW  word to transmit.
- `recording`  out  1  high in state REC.
- `playing`  out  1  high in state PLAY.
- `full`  out  1  high when `rec_len` = 2^AW.
- `rec_len`  out  AW+1  number of words held in RAM.

## Operation
- States: IDLE, REC, PLAY, PEND. PEND is the one-cycle RAM-prefetch state on entry to playback.
- Command priority, high to low: `stop`, `rec_start`, `play_start`.
- Start commands are accepted only in IDLE. In other states they are ignored.
- `stop` in any state returns to IDLE next cycle. It has no effect in IDLE.
- IDLE -> REC on `rec_start`:
  - `wr_addr` <= 0, `rec_len` <= 0, `full` <= 0.
- REC, on each `rx_done`:
  - RAM[`wr_addr`] <= `adc_data`; `wr_addr`++ and `rec_len`++.
  - When `rec_len` reaches 2^AW: `full` <= 1, go to IDLE.
  - On `stop`: a write strobed in the same cycle is still performed, then go to IDLE.
- IDLE -> PEND on `play_start`, only if `rec_len` != 0. If `rec_len` = 0 the pulse is ignored and the state stays IDLE.
- PEND: `rd_addr` = 0 is presented to the RAM. Next cycle `dac_data` <= RAM[0], go to PLAY.
- PLAY, on each `tx_done`:
  - `rd_addr`++.
  - If the new `rd_addr` = `rec_len`: go to IDLE, `dac_data` <= 0.
  - Otherwise `dac_data` <= RAM[`rd_addr`] two cycles after the strobe (registered address, registered RAM output).
- `rec_len` and RAM contents survive `stop` and return to IDLE, so playback can repeat.
- RAM is simple dual-port, inferred, not reset. Write has priority; no read-during-write hazard arises because REC and PLAY are exclusive.
- `rx_done` outside REC and `tx_done` outside PLAY are ignored.

## Timing
- Reset values: IDLE, `dac_data` = 0, `recording` = 0, `playing` = 0, `full` = 0, `rec_len` = 0, `wr_addr` = 0, `rd_addr` = 0.
- `recording` and `playing` are registered and follow state with no extra delay.
- A word written on `rx_done` in cycle N appears in `rec_len` at N+1.
- Playback start: `play_start` in cycle N -> PEND at N+1 -> `dac_data` = RAM[0] and `playing` = 1 at N+2.
- `tx_done` in cycle M -> `dac_data` updated at M+2. The codec frame guarantees at least 16 `clk` cycles before the word is sampled.
- Last word: `tx_done` at M with `rd_addr`+1 = `rec_len` -> IDLE and `dac_data` = 0 at M+1.
- Reset mid-REC: the partial `rec_len` is lost (cleared to 0). The RAM is untouched but treated as empty.

## Configuration
- `AUDIO_MONITOR_EN`:
  - Defined: in IDLE and REC, `dac_data` <= `adc_data` on each `rx_done` (live monitoring, one cycle latency). PLAY behaviour is unchanged. On PLAY -> IDLE the output is 0 until the next `rx_done`.
  - Undefined: `dac_data` is 0 in IDLE and REC.

## Test plan
- Reset, then 5 `rx_done` strobes in IDLE with `adc_data` = 0x12345678 -> `rec_len` = 0, `dac_data` = 0 (without macro).
- `rec_start`, then 4 `rx_done` with words 0x00010001..0x00040004, then `stop` -> `rec_len` = 4, IDLE. `play_start` -> `dac_data` = 0x00010001 two cycles later. The next 3 `tx_done` strobes step through 0x00020002, 0x00030003, 0x00040004. The 4th `tx_done` -> `dac_data` = 0, `playing` = 0.
- AW = 3: 10 `rx_done` in REC -> `full` = 1 and IDLE after the 8th strobe, `rec_len` = 8. The 9th and 10th words are not written.
- `play_start` with `rec_len` = 0 -> stays IDLE, `playing` = 0. Assert `rec_start` and `play_start` in the same cycle -> REC entered.
- `stop` and `rx_done` in the same REC cycle -> the word is stored, `rec_len` increments, IDLE. Assert `rst_n` low mid-PLAY -> all outputs return to reset values immediately.
- `AUDIO_MONITOR_EN` defined: `rx_done` with 0xAAAA5555 in IDLE -> `dac_data` = 0xAAAA5555 the next cycle.
